flit_send_port: RTL and testbench

- Parametrised, credit-aware send-side endpoint between a device bridge (valid/ready flit source) and one network send port (putFlit/getCredits).
- Buffers flits in a DEPTH-entry FIFO and tracks per-VC credits. It either honours the device-requested VC or allocates VCs round-robin per packet, then locks the VC until the tail flit.
- One instance per network send port; NUM_VCS, buffering and credit depth are set per network configuration.

---
 rtl/flit_send_port.sv | 160 ++++++++++++++++
 tb/tb_flit_send_port.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/flit_send_port.sv
// Credit-aware send endpoint: buffers device flits, tracks per-VC credits and
// presents one flit per cycle to the network, holding a VC for a whole packet.
module flit_send_port #(
  parameter int FLIT_WIDTH     = 38,
  parameter int DEST_BITS      = 2,
  parameter int NUM_VCS        = 2,
  parameter int VC_BITS        = $clog2(NUM_VCS),
  parameter int CREDITS_PER_VC = 4,
  parameter int DEPTH          = 8,
  parameter int VC_MODE        = 0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [FLIT_WIDTH-1:0]    put_flit,
  input  logic                     put_flit_valid,
  output logic                     put_flit_ready,
  output logic [FLIT_WIDTH-1:0]    send_putFlit_flit_in,
  output logic                     EN_send_putFlit,
  input  logic [VC_BITS:0]         send_getCredits,
  output logic                     EN_send_getCredits,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              flits_sent,
  output logic                     credit_error
);

  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = $clog2(CREDITS_PER_VC + 1);
  localparam int VALID_BIT = FLIT_WIDTH - 1;
  localparam int TAIL_BIT  = FLIT_WIDTH - 2;
  localparam int VC_LSB    = FLIT_WIDTH - 2 - DEST_BITS - VC_BITS;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS_PER_VC);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {VC_FREE, VC_HELD} lock_state_t;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]           count_reg, count_next;
  logic [CW-1:0]         cred_reg [NUM_VCS];
  logic [NUM_VCS-1:0]    cred_inc, cred_dec, cred_ovf;
  lock_state_t           lock_state_reg, lock_state_next;
  logic [VC_BITS-1:0]    lock_vc_reg, lock_vc_next;
  logic [VC_BITS-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [FLIT_WIDTH-1:0] out_flit_reg;
  logic                  out_en_reg;
  logic [15:0]           sent_reg;
  logic                  err_reg;

  logic                  full, accept, wr_en, do_send;
  logic [FLIT_WIDTH-1:0] head, send_flit;
  logic [VC_BITS-1:0]    rr_vc, free_vc, chosen_vc;

  assign full           = (count_reg == FULL_CNT);
  assign put_flit_ready = RST_N && !full;
  assign accept         = put_flit_valid && put_flit_ready;
  assign wr_en          = accept && put_flit[VALID_BIT];
  assign head           = mem[rd_ptr_reg];

  // Round-robin pick: first VC with credit, scanning upward from rr_ptr.
  always_comb begin
    logic [VC_BITS-1:0] idx;
    idx   = '0;
    rr_vc = rr_ptr_reg;
    for (int i = NUM_VCS - 1; i >= 0; i--) begin
      idx = rr_ptr_reg + VC_BITS'(i);
      if (cred_reg[idx] != '0) rr_vc = idx;
    end
  end

  assign free_vc   = (VC_MODE != 0) ? rr_vc : head[VC_LSB +: VC_BITS];
  assign chosen_vc = (lock_state_reg == VC_HELD) ? lock_vc_reg : free_vc;
  assign do_send   = (count_reg != '0) && (cred_reg[chosen_vc] != '0);

  always_comb begin
    send_flit                       = head;
    send_flit[VALID_BIT]            = 1'b1;
    send_flit[VC_LSB +: VC_BITS]    = chosen_vc;
  end

  always_comb begin
    lock_state_next = lock_state_reg;
    lock_vc_next    = lock_vc_reg;
    rr_ptr_next     = rr_ptr_reg;
    if (do_send) begin
      if (head[TAIL_BIT]) begin
        lock_state_next = VC_FREE;
        if (VC_MODE != 0) rr_ptr_next = chosen_vc + VC_BITS'(1);
      end else begin
        lock_state_next = VC_HELD;
        lock_vc_next    = chosen_vc;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({wr_en, do_send})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_cred
      assign cred_inc[gi] = send_getCredits[VC_BITS] &&
                            (send_getCredits[VC_BITS-1:0] == VC_BITS'(gi));
      assign cred_dec[gi] = do_send && (chosen_vc == VC_BITS'(gi));
      assign cred_ovf[gi] = cred_inc[gi] && !cred_dec[gi] && (cred_reg[gi] == CRED_MAX);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_reg] <= put_flit;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      lock_state_reg <= VC_FREE;
      lock_vc_reg    <= '0;
      rr_ptr_reg     <= '0;
      out_flit_reg   <= '0;
      out_en_reg     <= 1'b0;
      sent_reg       <= '0;
      err_reg        <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) cred_reg[v] <= CRED_MAX;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_send) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        out_flit_reg <= send_flit;
        sent_reg     <= sent_reg + 16'd1;
      end
      out_en_reg     <= do_send;
      count_reg      <= count_next;
      lock_state_reg <= lock_state_next;
      lock_vc_reg    <= lock_vc_next;
      rr_ptr_reg     <= rr_ptr_next;
      err_reg        <= err_reg | (|cred_ovf);
      // Simultaneous return and spend on one VC cancel out.
      for (int v = 0; v < NUM_VCS; v++) begin
        if (cred_inc[v] && !cred_dec[v] && cred_reg[v] != CRED_MAX)
          cred_reg[v] <= cred_reg[v] + 1'b1;
        else if (cred_dec[v] && !cred_inc[v])
          cred_reg[v] <= cred_reg[v] - 1'b1;
      end
    end
  end

  assign send_putFlit_flit_in = out_flit_reg;
  assign EN_send_putFlit      = out_en_reg;
  assign EN_send_getCredits   = RST_N;
  assign occupancy            = count_reg;
  assign flits_sent           = sent_reg;
  assign credit_error         = err_reg;

endmodule

// File: tb/tb_flit_send_port.sv
// Directed bench: cycle-vector table on a VC_MODE=0 instance, hand sequences
// on a round-robin instance for VC locking and mid-packet reset.
module tb_flit_send_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: VC_MODE=0, 2 credits/VC, 4-entry FIFO
  logic        r0_n, v0, rdy0, en0, gc0, err0;
  logic [37:0] f0, of0;
  logic [1:0]  c0;
  logic [2:0]  occ0;
  logic [15:0] fs0;

  // Instance 1: VC_MODE=1, 1 credit/VC, 4-entry FIFO
  logic        r1_n, v1, rdy1, en1, gc1, err1;
  logic [37:0] f1, of1;
  logic [1:0]  c1;
  logic [2:0]  occ1;
  logic [15:0] fs1;

  flit_send_port #(.NUM_VCS(2), .CREDITS_PER_VC(2), .DEPTH(4), .VC_MODE(0)) u0 (
    .CLK(clk), .RST_N(r0_n), .put_flit(f0), .put_flit_valid(v0), .put_flit_ready(rdy0),
    .send_putFlit_flit_in(of0), .EN_send_putFlit(en0), .send_getCredits(c0),
    .EN_send_getCredits(gc0), .occupancy(occ0), .flits_sent(fs0), .credit_error(err0));

  flit_send_port #(.NUM_VCS(2), .CREDITS_PER_VC(1), .DEPTH(4), .VC_MODE(1)) u1 (
    .CLK(clk), .RST_N(r1_n), .put_flit(f1), .put_flit_valid(v1), .put_flit_ready(rdy1),
    .send_putFlit_flit_in(of1), .EN_send_putFlit(en1), .send_getCredits(c1),
    .EN_send_getCredits(gc1), .occupancy(occ1), .flits_sent(fs1), .credit_error(err1));

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [37:0] flit;
    logic [1:0]  cr;
    logic        ready;
    logic        en;
    logic [37:0] oflit;
    logic [2:0]  occ;
    logic [15:0] fs;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [37:0] mk(input logic v, input logic t, input logic [1:0] d,
                                     input logic vc, input logic [32:0] p);
    return {v, t, d, vc, p};
  endfunction

  task automatic add(input logic rst_n, input logic valid, input logic [37:0] flit,
                     input logic [1:0] cr, input logic ready, input logic en,
                     input logic [37:0] oflit, input logic [2:0] occ,
                     input logic [15:0] fs, input logic err);
    vec_t t;
    t.rst_n = rst_n; t.valid = valid; t.flit = flit; t.cr = cr;
    t.ready = ready; t.en = en; t.oflit = oflit; t.occ = occ; t.fs = fs; t.err = err;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step1(input logic rst_n, input logic valid, input logic [37:0] flit,
                       input logic [1:0] cr);
    r1_n = rst_n; v1 = valid; f1 = flit; c1 = cr;
    @(posedge clk);
    #1;
    $display("u1 t=%0t rdy=%0b en=%0b out=%0h occ=%0d fs=%0d", $time, rdy1, en1, of1, occ1, fs1);
  endtask

  logic [37:0] A, B1, B2, B3, B4, B5, C1, C2, C3, C4, C5, C6, C7, D, E1, E2;
  logic [37:0] P0, P1, P2, Q, S, R0, R1, T;

  initial begin
    r0_n = 1'b0; v0 = 1'b0; f0 = '0; c0 = '0;
    r1_n = 1'b0; v1 = 1'b0; f1 = '0; c1 = '0;

    A  = mk(1, 1, 2'd1, 1'b0, 33'h11);
    B1 = mk(1, 1, 2'd2, 1'b1, 33'h21); B2 = mk(1, 1, 2'd2, 1'b1, 33'h22);
    B3 = mk(1, 1, 2'd2, 1'b1, 33'h23); B4 = mk(1, 1, 2'd2, 1'b1, 33'h24);
    B5 = mk(1, 1, 2'd2, 1'b1, 33'h25);
    C1 = mk(1, 1, 2'd3, 1'b0, 33'h31); C2 = mk(1, 1, 2'd3, 1'b0, 33'h32);
    C3 = mk(1, 1, 2'd3, 1'b0, 33'h33); C4 = mk(1, 1, 2'd3, 1'b0, 33'h34);
    C5 = mk(1, 1, 2'd3, 1'b0, 33'h35); C6 = mk(1, 1, 2'd3, 1'b0, 33'h36);
    C7 = mk(1, 1, 2'd3, 1'b0, 33'h37);
    D  = mk(1, 1, 2'd0, 1'b0, 33'h40);
    E1 = mk(1, 1, 2'd0, 1'b0, 33'h41); E2 = mk(1, 1, 2'd0, 1'b0, 33'h42);

    // rst valid flit cr | ready en oflit occ fs err
    for (int i = 0; i < 5; i++) add(0, 0, '0, 2'b00, 0, 0, '0, 0, 0, 0);
    add(1, 0, '0, 2'b00, 1, 0, '0, 0, 0, 0);
    add(1, 1, A,  2'b00, 1, 0, '0, 1, 0, 0);
    add(1, 0, '0, 2'b00, 1, 1, A,  0, 1, 0);
    add(1, 0, '0, 2'b10, 1, 0, '0, 0, 1, 0);
    add(1, 1, mk(0, 1, 2'd1, 1'b0, 33'h99), 2'b00, 1, 0, '0, 0, 1, 0);
    add(1, 0, '0, 2'b00, 1, 0, '0, 0, 1, 0);
    // credit exhaustion on vc1
    add(1, 1, B1, 2'b00, 1, 0, '0, 1, 1, 0);
    add(1, 1, B2, 2'b00, 1, 1, B1, 1, 2, 0);
    add(1, 1, B3, 2'b00, 1, 1, B2, 1, 3, 0);
    add(1, 0, '0, 2'b00, 1, 0, '0, 1, 3, 0);
    add(1, 0, '0, 2'b00, 1, 0, '0, 1, 3, 0);
    add(1, 0, '0, 2'b11, 1, 0, '0, 1, 3, 0);
    add(1, 0, '0, 2'b00, 1, 1, B3, 0, 4, 0);
    // same-cycle return and spend on vc1
    add(1, 0, '0, 2'b11, 1, 0, '0, 0, 4, 0);
    add(1, 1, B4, 2'b00, 1, 0, '0, 1, 4, 0);
    add(1, 0, '0, 2'b11, 1, 1, B4, 0, 5, 0);
    add(1, 1, B5, 2'b00, 1, 0, '0, 1, 5, 0);
    add(1, 0, '0, 2'b00, 1, 1, B5, 0, 6, 0);
    add(1, 0, '0, 2'b11, 1, 0, '0, 0, 6, 0);
    add(1, 0, '0, 2'b11, 1, 0, '0, 0, 6, 0);
    // FIFO fill on vc0
    add(1, 1, C1, 2'b00, 1, 0, '0, 1, 6, 0);
    add(1, 1, C2, 2'b00, 1, 1, C1, 1, 7, 0);
    add(1, 1, C3, 2'b00, 1, 1, C2, 1, 8, 0);
    add(1, 1, C4, 2'b00, 1, 0, '0, 2, 8, 0);
    add(1, 1, C5, 2'b00, 1, 0, '0, 3, 8, 0);
    add(1, 1, C6, 2'b00, 0, 0, '0, 4, 8, 0);
    add(1, 1, C7, 2'b00, 0, 0, '0, 4, 8, 0);
    add(1, 1, C7, 2'b10, 0, 0, '0, 4, 8, 0);
    add(1, 1, C7, 2'b00, 1, 1, C3, 3, 9, 0);
    add(1, 1, C7, 2'b00, 0, 0, '0, 4, 9, 0);
    add(1, 0, '0, 2'b10, 0, 0, '0, 4, 9, 0);
    add(1, 0, '0, 2'b10, 1, 1, C4, 3, 10, 0);
    add(1, 0, '0, 2'b10, 1, 1, C5, 2, 11, 0);
    add(1, 0, '0, 2'b10, 1, 1, C6, 1, 12, 0);
    add(1, 0, '0, 2'b10, 1, 1, C7, 0, 13, 0);
    add(1, 0, '0, 2'b10, 1, 0, '0, 0, 13, 0);
    // overflow: vc0 already full
    add(1, 0, '0, 2'b10, 1, 0, '0, 0, 13, 1);
    add(1, 1, D,  2'b00, 1, 0, '0, 1, 13, 1);
    add(1, 0, '0, 2'b00, 1, 1, D,  0, 14, 1);
    add(1, 1, E1, 2'b00, 1, 0, '0, 1, 14, 1);
    add(1, 1, E2, 2'b00, 1, 1, E1, 1, 15, 1);
    add(1, 0, '0, 2'b00, 1, 0, '0, 1, 15, 1);
    add(0, 0, '0, 2'b00, 0, 0, '0, 0, 0, 0);
    add(1, 0, '0, 2'b00, 1, 0, '0, 0, 0, 0);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      r0_n = tbl[i].rst_n; v0 = tbl[i].valid; f0 = tbl[i].flit; c0 = tbl[i].cr;
      @(posedge clk);
      #1;
      $display("u0 vec %0d rdy=%0b en=%0b out=%0h occ=%0d fs=%0d err=%0b",
               i, rdy0, en0, of0, occ0, fs0, err0);
      chk($sformatf("v%0d_ready", i), 64'(rdy0), 64'(tbl[i].ready));
      chk($sformatf("v%0d_en", i),    64'(en0),  64'(tbl[i].en));
      chk($sformatf("v%0d_getc", i),  64'(gc0),  64'(tbl[i].rst_n));
      chk($sformatf("v%0d_occ", i),   64'(occ0), 64'(tbl[i].occ));
      chk($sformatf("v%0d_sent", i),  64'(fs0),  64'(tbl[i].fs));
      chk($sformatf("v%0d_err", i),   64'(err0), 64'(tbl[i].err));
      if (tbl[i].en) chk($sformatf("v%0d_flit", i), 64'(of0), 64'(tbl[i].oflit));
    end

    // Round-robin VC lock on instance 1 (input vc fields deliberately 1)
    P0 = mk(1, 0, 2'd1, 1'b1, 33'h50); P1 = mk(1, 0, 2'd1, 1'b1, 33'h51);
    P2 = mk(1, 1, 2'd1, 1'b1, 33'h52); Q  = mk(1, 1, 2'd2, 1'b1, 33'h60);
    S  = mk(1, 1, 2'd0, 1'b1, 33'h70); R0 = mk(1, 0, 2'd3, 1'b1, 33'h80);
    R1 = mk(1, 0, 2'd3, 1'b1, 33'h81); T  = mk(1, 1, 2'd3, 1'b1, 33'h90);

    chk("rr_rst_ready", 64'(rdy1), 64'(0));
    chk("rr_rst_getc", 64'(gc1), 64'(0));
    step1(1, 0, '0, 2'b00);
    chk("rr_idle_ready", 64'(rdy1), 64'(1));
    chk("rr_idle_getc", 64'(gc1), 64'(1));
    step1(1, 1, P0, 2'b00);
    chk("rr_p0_occ", 64'(occ1), 64'(1));
    step1(1, 1, P1, 2'b00);
    chk("rr_head_en", 64'(en1), 64'(1));
    chk("rr_head_flit", 64'(of1), 64'(mk(1, 0, 2'd1, 1'b0, 33'h50)));
    step1(1, 1, P2, 2'b00);
    chk("rr_body_stall0", 64'(en1), 64'(0));
    chk("rr_body_occ", 64'(occ1), 64'(2));
    step1(1, 0, '0, 2'b00);
    chk("rr_body_stall1", 64'(en1), 64'(0));
    step1(1, 0, '0, 2'b10);
    chk("rr_body_stall2", 64'(en1), 64'(0));
    step1(1, 1, Q, 2'b00);
    chk("rr_body_en", 64'(en1), 64'(1));
    chk("rr_body_flit", 64'(of1), 64'(mk(1, 0, 2'd1, 1'b0, 33'h51)));
    step1(1, 0, '0, 2'b00);
    chk("rr_tail_stall", 64'(en1), 64'(0));
    step1(1, 0, '0, 2'b10);
    step1(1, 0, '0, 2'b10);
    chk("rr_tail_en", 64'(en1), 64'(1));
    chk("rr_tail_flit", 64'(of1), 64'(mk(1, 1, 2'd1, 1'b0, 33'h52)));
    step1(1, 0, '0, 2'b00);
    chk("rr_q_en", 64'(en1), 64'(1));
    chk("rr_q_flit", 64'(of1), 64'(mk(1, 1, 2'd2, 1'b1, 33'h60)));
    chk("rr_q_occ", 64'(occ1), 64'(0));
    step1(1, 0, '0, 2'b11);
    step1(1, 1, S, 2'b00);
    step1(1, 0, '0, 2'b00);
    chk("rr_s_flit", 64'(of1), 64'(mk(1, 1, 2'd0, 1'b0, 33'h70)));
    step1(1, 1, R0, 2'b10);
    step1(1, 1, R1, 2'b00);
    chk("rr_r0_en", 64'(en1), 64'(1));
    chk("rr_r0_flit", 64'(of1), 64'(mk(1, 0, 2'd3, 1'b1, 33'h80)));
    step1(1, 0, '0, 2'b00);
    chk("rr_r1_stall", 64'(en1), 64'(0));
    chk("rr_r1_occ", 64'(occ1), 64'(1));

    // Mid-packet asynchronous reset
    r1_n = 1'b0;
    #1;
    chk("mr_ready", 64'(rdy1), 64'(0));
    chk("mr_occ", 64'(occ1), 64'(0));
    chk("mr_getc", 64'(gc1), 64'(0));
    chk("mr_sent", 64'(fs1), 64'(0));
    chk("mr_flit", 64'(of1), 64'(0));
    @(posedge clk);
    #1;
    chk("mr_en", 64'(en1), 64'(0));
    step1(1, 1, T, 2'b00);
    chk("mr_t_occ", 64'(occ1), 64'(1));
    step1(1, 0, '0, 2'b00);
    chk("mr_t_en", 64'(en1), 64'(1));
    chk("mr_t_flit", 64'(of1), 64'(mk(1, 1, 2'd3, 1'b0, 33'h90)));
    chk("mr_t_occ0", 64'(occ1), 64'(0));
    chk("mr_t_sent", 64'(fs1), 64'(1));
    step1(1, 0, '0, 2'b00);
    chk("mr_t_en_off", 64'(en1), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
